// File: rtl/warbler_pkg.sv
// Shared constants, lane C word type and the feedback/filter functions used by
// the three Warbler NLFSR lanes.
package warbler_pkg;

    localparam int LEN_A   = 6;
    localparam int LEN_B   = 6;
    localparam int C_WORDS = 5;
    localparam int C_W     = 5;

    typedef logic [C_W-1:0] c_word_t;

    // Lane A nonlinear feedback
    function automatic logic fa(input logic [LEN_A-1:0] a);
        return a[0] ^ a[1] ^ (a[2] & a[4]);
    endfunction

    // Lane B WG-style nonlinear tap
    function automatic logic wgt(input logic [LEN_B-1:0] b);
        return b[1] ^ b[4] ^ (b[2] & b[3]) ^ (b[3] & b[5]);
    endfunction

    // Lane C word feedback; c1 enters rotated left by one bit
    function automatic c_word_t c_fb(input c_word_t c0, input c_word_t c1,
                                     input c_word_t c2, input c_word_t c4);
        return c0 ^ {c1[3:0], c1[4]} ^ (c2 & c4);
    endfunction

    function automatic logic wg_filter(input c_word_t c0);
        return (^(c0 & 5'b10101)) ^ (c0[1] & c0[3]);
    endfunction

endpackage

// File: rtl/warbler_c_reg.sv
// Lane C: five-word NLFSR with shift enable and the filtered output bit.
module warbler_c_reg
    import warbler_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    ce,
    input  logic    load,
    input  logic    init,
    input  c_word_t d,
    input  c_word_t tk,
    output logic    o_warbler
);

    c_word_t c_r [C_WORDS];
    c_word_t c_in_s;

    // Select the word entering c[4]: load beats init beats feedback
    always_comb begin
        c_in_s = c_fb(c_r[0], c_r[1], c_r[2], c_r[4]);
        if (load) begin
            c_in_s = d;
        end else if (init) begin
            c_in_s = tk;
        end else begin
            c_in_s = c_fb(c_r[0], c_r[1], c_r[2], c_r[4]);
        end
    end

    // Word shift register; ce low freezes the whole lane, including load/init
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_WORDS; i++) begin
                c_r[i] <= {C_W{1'b0}};
            end
        end else if (ce) begin
            for (int i = 0; i < C_WORDS - 1; i++) begin
                c_r[i] <= c_r[i+1];
            end
            c_r[C_WORDS-1] <= c_in_s;
        end else begin
            for (int i = 0; i < C_WORDS; i++) begin
                c_r[i] <= c_r[i];
            end
        end
    end

    // Zero-latency filter of the registered head word
    assign o_warbler = wg_filter(c_r[0]);

endmodule

// File: rtl/warbler_nlfsr_core.sv
// Three shift-register lanes of the Warbler PRNG/TRNG mixer: bit lanes A and B
// inline, word lane C in warbler_c_reg.
module warbler_nlfsr_core
    import warbler_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           warbler_o1,
    input  logic           nlfsr3_ce1,
    input  logic           d1,
    input  logic           init1,
    input  logic           load1,
    output logic           a0,
    input  logic           warbler_o2,
    input  logic           nlfsr3_ce2,
    input  logic           d2,
    input  logic           init2,
    input  logic           load2,
    output logic           b0,
    input  logic           nlfsr3_ce3,
    input  logic [C_W-1:0] d3,
    input  logic [C_W-1:0] tk,
    input  logic           init3,
    input  logic           load3,
    output logic           o_warbler
);

    logic [LEN_A-1:0] a_r;
    logic [LEN_B-1:0] b_r;
    logic             a_in_s;
    logic             b_in_s;

    // Bit entering each lane's top cell; the ce inputs only gate the mix bit
    always_comb begin
        a_in_s = 1'b0;
        b_in_s = 1'b0;
        if (load1) begin
            a_in_s = d1;
        end else if (init1) begin
            a_in_s = warbler_o1;
        end else begin
            a_in_s = fa(a_r) ^ (nlfsr3_ce1 & warbler_o1);
        end
        if (load2) begin
            b_in_s = d2;
        end else if (init2) begin
            b_in_s = warbler_o2;
        end else begin
            b_in_s = wgt(b_r) ^ b_r[0] ^ (nlfsr3_ce2 & warbler_o2);
        end
    end

    // Lanes A and B shift on every clock
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {LEN_A{1'b0}};
            b_r <= {LEN_B{1'b0}};
        end else begin
            a_r <= {a_in_s, a_r[LEN_A-1:1]};
            b_r <= {b_in_s, b_r[LEN_B-1:1]};
        end
    end

    assign a0 = a_r[0];
    assign b0 = b_r[0];

    warbler_c_reg u_c_reg (
        .clk       (clk),
        .rst       (rst),
        .ce        (nlfsr3_ce3),
        .load      (load3),
        .init      (init3),
        .d         (d3),
        .tk        (tk),
        .o_warbler (o_warbler)
    );

endmodule

// File: tb/tb_warbler_nlfsr_core.sv
// Scoreboarded bench for warbler_nlfsr_core: a bit-level lane model predicts
// a0/b0/o_warbler every cycle, and scenario tasks add directed checks.
module tb_warbler_nlfsr_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       warbler_o1, nlfsr3_ce1, d1, init1, load1;
    logic       warbler_o2, nlfsr3_ce2, d2, init2, load2;
    logic       nlfsr3_ce3, init3, load3;
    logic [4:0] d3, tk;
    logic       a0, b0, o_warbler;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] ma, mb;
    logic [4:0] mc [5];
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    warbler_nlfsr_core dut (
        .clk        (clk),
        .rst        (rst),
        .warbler_o1 (warbler_o1),
        .nlfsr3_ce1 (nlfsr3_ce1),
        .d1         (d1),
        .init1      (init1),
        .load1      (load1),
        .a0         (a0),
        .warbler_o2 (warbler_o2),
        .nlfsr3_ce2 (nlfsr3_ce2),
        .d2         (d2),
        .init2      (init2),
        .load2      (load2),
        .b0         (b0),
        .nlfsr3_ce3 (nlfsr3_ce3),
        .d3         (d3),
        .tk         (tk),
        .init3      (init3),
        .load3      (load3),
        .o_warbler  (o_warbler)
    );

    function automatic logic m_filter(input logic [4:0] w);
        logic p;
        p = w[0] ^ w[2] ^ w[4];
        return p ^ (w[1] & w[3]);
    endfunction

    // Advance the model by one clock with the current inputs, queue the
    // expected outputs, then let the DUT take the same edge.
    task automatic step();
        logic       ain, bin;
        logic [4:0] cin, rot;
        if (rst) begin
            ma = 6'd0;
            mb = 6'd0;
            for (int i = 0; i < 5; i++) mc[i] = 5'd0;
        end else begin
            if (load1)      ain = d1;
            else if (init1) ain = warbler_o1;
            else            ain = ma[0] ^ ma[1] ^ (ma[2] & ma[4]) ^ (nlfsr3_ce1 & warbler_o1);
            if (load2)      bin = d2;
            else if (init2) bin = warbler_o2;
            else            bin = mb[1] ^ mb[4] ^ (mb[2] & mb[3]) ^ (mb[3] & mb[5])
                                  ^ mb[0] ^ (nlfsr3_ce2 & warbler_o2);
            ma = {ain, ma[5:1]};
            mb = {bin, mb[5:1]};
            if (nlfsr3_ce3) begin
                rot = {mc[1][3:0], mc[1][4]};
                if (load3)      cin = d3;
                else if (init3) cin = tk;
                else            cin = mc[0] ^ rot ^ (mc[2] & mc[4]);
                for (int i = 0; i < 4; i++) mc[i] = mc[i+1];
                mc[4] = cin;
            end
        end
        exp_q.push_back({ma[0], mb[0], m_filter(mc[0])});
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each queued expectation once outputs have settled
    always @(negedge clk) begin
        logic [2:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if ({a0, b0, o_warbler} !== exp_v) begin
                tests_failed++;
                $display("FAIL scoreboard t=%0t: a0,b0,o_warbler=%b expected %b",
                         $time, {a0, b0, o_warbler}, exp_v);
            end
        end
    end

    task automatic clear_inputs();
        rst = 1'b0;
        warbler_o1 = 1'b0; nlfsr3_ce1 = 1'b0; d1 = 1'b0; init1 = 1'b0; load1 = 1'b0;
        warbler_o2 = 1'b0; nlfsr3_ce2 = 1'b0; d2 = 1'b0; init2 = 1'b0; load2 = 1'b0;
        nlfsr3_ce3 = 1'b0; init3 = 1'b0; load3 = 1'b0; d3 = 5'd0; tk = 5'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests_run++;
        if ({a0, b0, o_warbler} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset: outputs=%b expected 000", {a0, b0, o_warbler});
        end
    endtask

    task automatic test_lane_a_init();
        do_reset();
        init1 = 1'b1; warbler_o1 = 1'b1;
        for (int i = 0; i < 6; i++) step();
        tests_run++;
        if (a0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lane_a_init: a0=%b expected 1", a0);
        end
        clear_inputs();
    endtask

    task automatic test_lane_b_load();
        do_reset();
        load2 = 1'b1; d2 = 1'b1;
        step();
        load2 = 1'b0; init2 = 1'b1; warbler_o2 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (b0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lane_b_load_bit4: b0=%b expected 1", b0);
        end
        step();
        tests_run++;
        if (b0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lane_b_init_bit5: b0=%b expected 0", b0);
        end
        clear_inputs();
    endtask

    task automatic test_lane_c_init();
        do_reset();
        init3 = 1'b1; nlfsr3_ce3 = 1'b1; tk = 5'h01;
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (o_warbler !== 1'b1) begin
            tests_failed++;
            $display("FAIL lane_c_init_tk1: o_warbler=%b expected 1", o_warbler);
        end
        tk = 5'h05;
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (o_warbler !== 1'b0) begin
            tests_failed++;
            $display("FAIL lane_c_init_tk5: o_warbler=%b expected 0", o_warbler);
        end
    endtask

    // Continues from the all-5'h05 lane C left by test_lane_c_init
    task automatic test_lane_c_hold();
        nlfsr3_ce3 = 1'b0; init3 = 1'b0; load3 = 1'b1; d3 = 5'h03;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (o_warbler !== 1'b0) begin
            tests_failed++;
            $display("FAIL lane_c_hold: o_warbler=%b expected 0", o_warbler);
        end
        nlfsr3_ce3 = 1'b1;
        step();
        load3 = 1'b0; init3 = 1'b1; tk = 5'h05;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (o_warbler !== 1'b0) begin
            tests_failed++;
            $display("FAIL lane_c_hold_shift: o_warbler=%b expected 0", o_warbler);
        end
        step();
        tests_run++;
        if (o_warbler !== 1'b1) begin
            tests_failed++;
            $display("FAIL lane_c_load_reaches_head: o_warbler=%b expected 1", o_warbler);
        end
        clear_inputs();
    endtask

    task automatic test_load_priority();
        do_reset();
        init1 = 1'b1; warbler_o1 = 1'b1;
        init2 = 1'b1; warbler_o2 = 1'b1;
        init3 = 1'b1; nlfsr3_ce3 = 1'b1; tk = 5'h05;
        for (int i = 0; i < 6; i++) step();
        load1 = 1'b1; d1 = 1'b0;
        load2 = 1'b1; d2 = 1'b0;
        load3 = 1'b1; d3 = 5'h01;
        for (int i = 0; i < 6; i++) step();
        tests_run++;
        if ({a0, b0, o_warbler} !== 3'b001) begin
            tests_failed++;
            $display("FAIL load_over_init: a0,b0,o_warbler=%b expected 001",
                     {a0, b0, o_warbler});
        end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        init1 = 1'b1; init2 = 1'b1; init3 = 1'b1; nlfsr3_ce3 = 1'b1;
        nlfsr3_ce1 = 1'b1; nlfsr3_ce2 = 1'b1;
        warbler_o1 = 1'b1; warbler_o2 = 1'b1; tk = 5'h01;
        for (int i = 0; i < 6; i++) step();
        load1 = 1'b1; d1 = 1'b1; load2 = 1'b1; d2 = 1'b1; load3 = 1'b1; d3 = 5'h1f;
        rst = 1'b1;
        step();
        tests_run++;
        if ({a0, b0, o_warbler} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset: outputs=%b expected 000", {a0, b0, o_warbler});
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            warbler_o1 = 1'($urandom_range(0, 1));
            nlfsr3_ce1 = 1'($urandom_range(0, 1));
            d1         = 1'($urandom_range(0, 1));
            init1      = ($urandom_range(0, 5) == 0);
            load1      = ($urandom_range(0, 7) == 0);
            warbler_o2 = 1'($urandom_range(0, 1));
            nlfsr3_ce2 = 1'($urandom_range(0, 1));
            d2         = 1'($urandom_range(0, 1));
            init2      = ($urandom_range(0, 5) == 0);
            load2      = ($urandom_range(0, 7) == 0);
            nlfsr3_ce3 = ($urandom_range(0, 3) != 0);
            init3      = (i < 8) || ($urandom_range(0, 7) == 0);
            load3      = ($urandom_range(0, 7) == 0);
            d3         = 5'($urandom_range(0, 31));
            tk         = 5'($urandom_range(1, 31));
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_lane_a_init();
        test_lane_b_load();
        test_lane_c_init();
        test_lane_c_hold();
        test_load_priority();
        test_mid_reset();
        test_back_to_back();
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
